// File: rtl/residual_block_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : residual_block_scheduler_pkg                                   |
// | Purpose : Shared encodings for the residual block scheduler: block-class |
// |           codes driven on blk_type, FSM state codes, and the maximum     |
// |           coefficient counts per block class.                            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package residual_block_scheduler_pkg;

  // Block class codes (blk_type)
  localparam logic [2:0] BLK_LUMA4x4 = 3'd0;
  localparam logic [2:0] BLK_I16DC   = 3'd1;
  localparam logic [2:0] BLK_I16AC   = 3'd2;
  localparam logic [2:0] BLK_CHDC    = 3'd3;
  localparam logic [2:0] BLK_CHAC    = 3'd4;

  // FSM state codes
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_I16_DC    = 3'd1;
  localparam logic [2:0] ST_LUMA      = 3'd2;
  localparam logic [2:0] ST_I16_AC    = 3'd3;
  localparam logic [2:0] ST_CHROMA_DC = 3'd4;
  localparam logic [2:0] ST_CHROMA_AC = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  // Maximum coefficient counts
  localparam int MAXC_CHDC = 4;
  localparam int MAXC_AC   = 15;
  localparam int MAXC_FULL = 16;

endpackage : residual_block_scheduler_pkg
`default_nettype wire

// File: rtl/residual_block_scheduler_next_coded_blk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : residual_block_scheduler_next_coded_blk                        |
// | Purpose : Combinational search for the first luma 4x4 index >= from     |
// |           whose 8x8 group bit is set in cbp_luma.                        |
// | Ports   : from[4:0]     in  start position 0..16 (16 = past the end)     |
// |           cbp_luma[3:0] in  coded 8x8 groups                             |
// |           found         out a coded index exists at or after from        |
// |           idx[3:0]      out that index (0 when not found)                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module residual_block_scheduler_next_coded_blk (
  input  logic [4:0] from,
  input  logic [3:0] cbp_luma,
  output logic       found,
  output logic [3:0] idx
);

  logic [1:0] grp;
  logic [2:0] above;  // coded groups strictly after grp; bit n = group n+1

  assign grp   = from[3:2];
  assign above = cbp_luma[3:1] & (3'b111 << grp);

  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    if (!from[4]) begin
      if (cbp_luma[grp]) begin
        // Still inside a coded group: the next index is simply 'from'.
        found = 1'b1;
        idx   = from[3:0];
      end else if (above[0]) begin
        found = 1'b1;
        idx   = 4'd4;
      end else if (above[1]) begin
        found = 1'b1;
        idx   = 4'd8;
      end else if (above[2]) begin
        found = 1'b1;
        idx   = 4'd12;
      end
    end
  end

endmodule : residual_block_scheduler_next_coded_blk
`default_nettype wire

// File: rtl/residual_block_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : residual_block_scheduler                                       |
// | Purpose : Issues the residual blocks of one macroblock in H.264 order    |
// |           (I16 DC/AC or luma 4x4, chroma DC, chroma AC), one block per   |
// |           valid/done handshake, then pulses mb_done.                     |
// | Ports   : clk, reset_n (sync, active-low)                                |
// |           start, mb_is_i16, cbp_luma[3:0], cbp_chroma[1:0]  MB inputs    |
// |           blk_done                      block accepted by CAVLC          |
// |           blk_valid, blk_type[2:0], blk_idx[3:0], blk_comp,              |
// |           max_num_coeff[MAXC_W-1:0], blk_skip   block request            |
// |           busy, mb_done                 MB status                        |
// | Config  : RESIDUAL_SKIP_STROBE_EN - one blk_skip cycle per uncoded 4x4   |
// |           position instead of jumping over it.                           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module residual_block_scheduler
  import residual_block_scheduler_pkg::*;
#(
  parameter int MAXC_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mb_is_i16,
  input  logic [3:0]        cbp_luma,
  input  logic [1:0]        cbp_chroma,
  input  logic              blk_done,
  output logic              blk_valid,
  output logic [2:0]        blk_type,
  output logic [3:0]        blk_idx,
  output logic              blk_comp,
  output logic [MAXC_W-1:0] max_num_coeff,
  output logic              blk_skip,
  output logic              busy,
  output logic              mb_done
);

  logic [2:0] state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       comp, next_comp;
  logic       lat_i16;
  logic [3:0] lat_cbp_luma;
  logic [1:0] lat_cbp_chroma;

  // In IDLE the first block is chosen from the live inputs on the start edge.
  logic       eff_i16;
  logic [1:0] eff_cbp_chroma;
  logic       in_blk;
  logic       advance;
  logic [2:0] chroma_entry;
  logic [2:0] chroma_after_dc;

  assign eff_i16        = (state == ST_IDLE) ? mb_is_i16  : lat_i16;
  assign eff_cbp_chroma = (state == ST_IDLE) ? cbp_chroma : lat_cbp_chroma;
  assign in_blk         = (state == ST_I16_DC) || (state == ST_LUMA) || (state == ST_I16_AC) ||
                          (state == ST_CHROMA_DC) || (state == ST_CHROMA_AC);
  assign advance        = (blk_valid & blk_done) | blk_skip;

`ifdef RESIDUAL_SKIP_STROBE_EN
  // Chroma AC positions are always walked so each gets either a block or a strobe.
  assign chroma_entry    = (eff_cbp_chroma != 2'd0) ? ST_CHROMA_DC : ST_CHROMA_AC;
  assign chroma_after_dc = ST_CHROMA_AC;
`else
  logic [3:0] eff_cbp_luma;
  logic [4:0] search_from;
  logic       luma_found;
  logic [3:0] luma_idx;

  assign eff_cbp_luma    = (state == ST_IDLE) ? cbp_luma : lat_cbp_luma;
  assign search_from     = (state == ST_IDLE) ? 5'd0 : ({1'b0, cnt} + 5'd1);
  assign chroma_entry    = (eff_cbp_chroma != 2'd0) ? ST_CHROMA_DC : ST_DONE;
  assign chroma_after_dc = (lat_cbp_chroma == 2'd2) ? ST_CHROMA_AC : ST_DONE;

  residual_block_scheduler_next_coded_blk u_next_coded_blk (
    .from     (search_from),
    .cbp_luma (eff_cbp_luma),
    .found    (luma_found),
    .idx      (luma_idx)
  );
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= 4'd0;
      comp           <= 1'b0;
      lat_i16        <= 1'b0;
      lat_cbp_luma   <= 4'd0;
      lat_cbp_chroma <= 2'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      comp  <= next_comp;
      if (state == ST_IDLE && start) begin
        lat_i16        <= mb_is_i16;
        lat_cbp_luma   <= cbp_luma;
        lat_cbp_chroma <= cbp_chroma;
      end
    end
  end

  // Next-state logic: every phase change resets cnt/comp to the first position.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_comp  = comp;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_comp = 1'b0;
          next_cnt  = 4'd0;
          if (eff_i16) begin
            next_state = ST_I16_DC;
          end else begin
`ifdef RESIDUAL_SKIP_STROBE_EN
            next_state = ST_LUMA;
`else
            if (luma_found) begin
              next_state = ST_LUMA;
              next_cnt   = luma_idx;
            end else begin
              next_state = chroma_entry;
            end
`endif
          end
        end
      end
      ST_I16_DC: begin
        if (advance) begin
          next_cnt = 4'd0;
`ifdef RESIDUAL_SKIP_STROBE_EN
          next_state = ST_I16_AC;
`else
          next_state = (lat_cbp_luma == 4'hF) ? ST_I16_AC : chroma_entry;
`endif
        end
      end
      ST_LUMA: begin
        if (advance) begin
`ifdef RESIDUAL_SKIP_STROBE_EN
          if (cnt != 4'd15) begin
            next_cnt = cnt + 4'd1;
          end else begin
            next_cnt   = 4'd0;
            next_state = chroma_entry;
          end
`else
          if (luma_found) begin
            next_cnt = luma_idx;
          end else begin
            next_cnt   = 4'd0;
            next_state = chroma_entry;
          end
`endif
        end
      end
      ST_I16_AC: begin
        if (advance) begin
          if (cnt != 4'd15) begin
            next_cnt = cnt + 4'd1;
          end else begin
            next_cnt   = 4'd0;
            next_state = chroma_entry;
          end
        end
      end
      ST_CHROMA_DC: begin
        if (advance) begin
          if (!comp) begin
            next_comp = 1'b1;
          end else begin
            next_comp  = 1'b0;
            next_cnt   = 4'd0;
            next_state = chroma_after_dc;
          end
        end
      end
      ST_CHROMA_AC: begin
        if (advance) begin
          next_cnt = cnt + 4'd1;
          if (cnt == 4'd3) begin
            next_cnt = 4'd0;
            if (!comp) begin
              next_comp = 1'b1;
            end else begin
              next_comp  = 1'b0;
              next_state = ST_DONE;
            end
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    blk_type      = BLK_LUMA4x4;
    blk_idx       = 4'd0;
    blk_comp      = 1'b0;
    max_num_coeff = '0;
    busy          = (state != ST_IDLE);
    mb_done       = (state == ST_DONE);
    case (state)
      ST_I16_DC: begin
        blk_type      = BLK_I16DC;
        max_num_coeff = MAXC_W'(MAXC_FULL);
      end
      ST_LUMA: begin
        blk_type      = BLK_LUMA4x4;
        blk_idx       = cnt;
        max_num_coeff = MAXC_W'(MAXC_FULL);
      end
      ST_I16_AC: begin
        blk_type      = BLK_I16AC;
        blk_idx       = cnt;
        max_num_coeff = MAXC_W'(MAXC_AC);
      end
      ST_CHROMA_DC: begin
        blk_type      = BLK_CHDC;
        blk_comp      = comp;
        max_num_coeff = MAXC_W'(MAXC_CHDC);
      end
      ST_CHROMA_AC: begin
        blk_type      = BLK_CHAC;
        blk_idx       = cnt;
        blk_comp      = comp;
        max_num_coeff = MAXC_W'(MAXC_AC);
      end
      default: ;
    endcase
`ifdef RESIDUAL_SKIP_STROBE_EN
    blk_valid = 1'b0;
    blk_skip  = 1'b0;
    if (in_blk) begin
      case (state)
        ST_LUMA:      blk_valid = lat_cbp_luma[cnt[3:2]];
        ST_I16_AC:    blk_valid = (lat_cbp_luma == 4'hF);
        ST_CHROMA_AC: blk_valid = (lat_cbp_chroma == 2'd2);
        default:      blk_valid = 1'b1;
      endcase
      blk_skip = ~blk_valid;
    end
`else
    // Only coded positions are ever visited.
    blk_valid = in_blk;
    blk_skip  = 1'b0;
`endif
  end

endmodule : residual_block_scheduler
`default_nettype wire

// File: tb/tb_residual_block_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_residual_block_scheduler                                    |
// | Purpose : Directed self-checking bench for residual_block_scheduler.     |
// |           Honours RESIDUAL_SKIP_STROBE_EN when defined.                  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_residual_block_scheduler;

  localparam logic [2:0] T_LUMA = 3'd0;
  localparam logic [2:0] T_I16DC = 3'd1;
  localparam logic [2:0] T_I16AC = 3'd2;
  localparam logic [2:0] T_CHDC = 3'd3;
  localparam logic [2:0] T_CHAC = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       mb_is_i16;
  logic [3:0] cbp_luma;
  logic [1:0] cbp_chroma;
  logic       blk_done;
  logic       blk_valid;
  logic [2:0] blk_type;
  logic [3:0] blk_idx;
  logic       blk_comp;
  logic [4:0] max_num_coeff;
  logic       blk_skip;
  logic       busy;
  logic       mb_done;

  int tests = 0;
  int fails = 0;

  residual_block_scheduler #(.MAXC_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .mb_is_i16     (mb_is_i16),
    .cbp_luma      (cbp_luma),
    .cbp_chroma    (cbp_chroma),
    .blk_done      (blk_done),
    .blk_valid     (blk_valid),
    .blk_type      (blk_type),
    .blk_idx       (blk_idx),
    .blk_comp      (blk_comp),
    .max_num_coeff (max_num_coeff),
    .blk_skip      (blk_skip),
    .busy          (busy),
    .mb_done       (mb_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic v, input logic s, input logic [2:0] t,
                         input logic [3:0] i, input logic c, input logic [4:0] m);
    chk({tag, ".valid"}, blk_valid, v);
    chk({tag, ".skip"}, blk_skip, s);
    chk({tag, ".type"}, blk_type, t);
    chk({tag, ".idx"}, blk_idx, i);
    chk({tag, ".comp"}, blk_comp, c);
    chk({tag, ".mb_done"}, mb_done, 1'b0);
    if (v) chk({tag, ".max"}, max_num_coeff, m);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".mb_done"}, mb_done, 1'b1);
    chk({tag, ".valid"}, blk_valid, 1'b0);
    chk({tag, ".busy"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, ".idle_busy"}, busy, 1'b0);
    chk({tag, ".idle_done"}, mb_done, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".valid"}, blk_valid, 1'b0);
    chk({tag, ".skip"}, blk_skip, 1'b0);
    chk({tag, ".type"}, blk_type, 3'd0);
    chk({tag, ".idx"}, blk_idx, 4'd0);
    chk({tag, ".comp"}, blk_comp, 1'b0);
    chk({tag, ".max"}, max_num_coeff, 5'd0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".mb_done"}, mb_done, 1'b0);
  endtask

  task automatic begin_mb(input logic i16, input logic [3:0] cl, input logic [1:0] cc);
    mb_is_i16  = i16;
    cbp_luma   = cl;
    cbp_chroma = cc;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Eight chroma AC skip strobes: Cb 0..3 then Cr 0..3.
  task automatic chk_chac_skips(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk_blk($sformatf("%s.chac%0d", tag, k), 1'b0, 1'b1, T_CHAC, 4'(k % 4), (k >= 4), 5'd15);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    mb_is_i16  = 1'b0;
    cbp_luma   = 4'd0;
    cbp_chroma = 2'd0;
    blk_done   = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    // 1: non-I16, cbp_luma=0101, no chroma, done held high; a start mid-MB is ignored.
    blk_done = 1'b1;
    begin_mb(1'b0, 4'b0101, 2'd0);
    chk("t1.busy", busy, 1'b1);
`ifdef RESIDUAL_SKIP_STROBE_EN
    for (int p = 0; p < 16; p++) begin
      chk_blk($sformatf("t1.p%0d", p), ((p / 4) % 2 == 0), ((p / 4) % 2 == 1), T_LUMA, 4'(p), 1'b0, 5'd16);
      if (p == 2) begin start = 1'b1; cbp_luma = 4'hF; end
      @(negedge clk);
      start = 1'b0;
    end
    chk_chac_skips("t1");
`else
    for (int k = 0; k < 8; k++) begin
      chk_blk($sformatf("t1.b%0d", k), 1'b1, 1'b0, T_LUMA, 4'((k < 4) ? k : k + 4), 1'b0, 5'd16);
      if (k == 2) begin start = 1'b1; cbp_luma = 4'hF; end
      @(negedge clk);
      start = 1'b0;
    end
`endif
    chk_done("t1");

    // 2: I16, cbp_luma=0, chroma DC+AC.
    begin_mb(1'b1, 4'h0, 2'd2);
    chk_blk("t2.dc", 1'b1, 1'b0, T_I16DC, 4'd0, 1'b0, 5'd16);
    @(negedge clk);
`ifdef RESIDUAL_SKIP_STROBE_EN
    for (int p = 0; p < 16; p++) begin
      chk_blk($sformatf("t2.acskip%0d", p), 1'b0, 1'b1, T_I16AC, 4'(p), 1'b0, 5'd15);
      @(negedge clk);
    end
`endif
    chk_blk("t2.cbdc", 1'b1, 1'b0, T_CHDC, 4'd0, 1'b0, 5'd4);
    @(negedge clk);
    chk_blk("t2.crdc", 1'b1, 1'b0, T_CHDC, 4'd0, 1'b1, 5'd4);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk_blk($sformatf("t2.ac%0d", k), 1'b1, 1'b0, T_CHAC, 4'(k % 4), (k >= 4), 5'd15);
      @(negedge clk);
    end
    chk_done("t2");

`ifndef RESIDUAL_SKIP_STROBE_EN
    // 3: nothing coded: DONE right after start, busy for one cycle.
    begin_mb(1'b0, 4'h0, 2'd0);
    chk("t3.valid", blk_valid, 1'b0);
    chk_done("t3");
`endif

    // 4: blk_done while idle is ignored; then done every 3rd cycle, fields held.
    blk_done = 1'b1;
    @(negedge clk);
    chk("t4.idle_busy", busy, 1'b0);
    chk("t4.idle_valid", blk_valid, 1'b0);
    blk_done = 1'b0;
    begin_mb(1'b0, 4'hF, 2'd0);
    for (int k = 0; k < 16; k++) begin
      blk_done = 1'b0;
      chk_blk($sformatf("t4.b%0dw0", k), 1'b1, 1'b0, T_LUMA, 4'(k), 1'b0, 5'd16);
      @(negedge clk);
      chk_blk($sformatf("t4.b%0dw1", k), 1'b1, 1'b0, T_LUMA, 4'(k), 1'b0, 5'd16);
      @(negedge clk);
      chk_blk($sformatf("t4.b%0dw2", k), 1'b1, 1'b0, T_LUMA, 4'(k), 1'b0, 5'd16);
      blk_done = 1'b1;
      @(negedge clk);
    end
    blk_done = 1'b0;
`ifdef RESIDUAL_SKIP_STROBE_EN
    chk_chac_skips("t4");
`endif
    chk_done("t4");

    // 5: reset during LUMA idx5 aborts without mb_done; a new start begins at idx0.
    blk_done = 1'b1;
    begin_mb(1'b0, 4'hF, 2'd0);
    for (int k = 0; k < 6; k++) begin
      chk_blk($sformatf("t5.b%0d", k), 1'b1, 1'b0, T_LUMA, 4'(k), 1'b0, 5'd16);
      if (k == 5) reset_n = 1'b0;
      @(negedge clk);
    end
    chk_idle_outputs("t5.abort");
    reset_n = 1'b1;
    begin_mb(1'b0, 4'hF, 2'd0);
    chk_blk("t5.restart", 1'b1, 1'b0, T_LUMA, 4'd0, 1'b0, 5'd16);
    reset_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5.reset2");
    reset_n = 1'b1;
    @(negedge clk);

`ifdef RESIDUAL_SKIP_STROBE_EN
    // 6: non-I16, cbp_luma=0010, chroma DC only: strobes on every uncoded position.
    blk_done = 1'b1;
    begin_mb(1'b0, 4'b0010, 2'd1);
    for (int p = 0; p < 16; p++) begin
      chk_blk($sformatf("t6.p%0d", p), (p >= 4 && p < 8), !(p >= 4 && p < 8), T_LUMA, 4'(p), 1'b0, 5'd16);
      @(negedge clk);
    end
    chk_blk("t6.cbdc", 1'b1, 1'b0, T_CHDC, 4'd0, 1'b0, 5'd4);
    @(negedge clk);
    chk_blk("t6.crdc", 1'b1, 1'b0, T_CHDC, 4'd0, 1'b1, 5'd4);
    @(negedge clk);
    chk_chac_skips("t6");
    chk_done("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_residual_block_scheduler
`default_nettype wire
